// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM duty sequencer and its debouncers.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE_UP = 2'd1,
        PULSE_DN = 2'd2,
        HOLD     = 2'd3
    } pwm_state_t;

    localparam int DEF_STEPS           = 10;
    localparam int DEF_LVL_W           = 4;
    localparam int DEF_PULSE_CYCLES    = 2;
    localparam int DEF_RAMP_DIV        = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: emits a one-cycle press pulse after DEBOUNCE_CYCLES stable-high samples.
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The count saturates at CNT_MAX so a long hold fires only once.
    always_comb begin
        cnt_d   = '0;
        press_d = 1'b0;
        if (i_raw) begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            press_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Steps a 10%-granular PWM up/down from debounced buttons or a rate-limited target ramp,
// tracking the PWM level in a shadow register so it never steps past 0 or full scale.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int STEPS           = DEF_STEPS,
    parameter int LVL_W           = DEF_LVL_W,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int RAMP_DIV        = DEF_RAMP_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic             i_auto_en,
    input  logic             i_target_valid,
    input  logic [LVL_W-1:0] i_target,
    output logic             o_target_ready,
    output logic             o_increase_duty,
    output logic             o_decrease_duty,
    output logic [LVL_W-1:0] o_duty_level,
    output logic             o_busy,
    output logic             o_at_target,
    output pwm_state_t       o_dbg_state
);

    // Target handshake: a target is taken on any cycle where i_target_valid and
    // o_target_ready are both high; ready stays high so retargeting mid-ramp is allowed.

    localparam int CNT_MAX_I = (PULSE_CYCLES > RAMP_DIV) ? PULSE_CYCLES : RAMP_DIV;
    localparam int CNT_W     = $clog2(CNT_MAX_I + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RAMP_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(STEPS);

    pwm_state_t       state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_up_q, pend_up_d;
    logic             pend_dn_q, pend_dn_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             busy_q, busy_d;
    logic             at_target_q, at_target_d;
    logic             ready_q;

    logic press_up, press_dn;
    logic up_req, dn_req;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_btn_up),
        .o_press(press_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_btn_down),
        .o_press(press_dn)
    );

    assign up_req = i_auto_en ? (target_q > level_q) : pend_up_q;
    assign dn_req = i_auto_en ? (target_q < level_q) : pend_dn_q;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        inc_d     = inc_q;
        dec_d     = dec_q;
        pend_up_d = i_auto_en ? 1'b0 : (pend_up_q | press_up);
        pend_dn_d = i_auto_en ? 1'b0 : (pend_dn_q | press_dn);

        if (i_target_valid && ready_q) begin
            target_d = (i_target > LVL_MAX) ? LVL_MAX : i_target;
        end

        case (state_q)
            IDLE: begin
                // Requests that would step past a rail are dropped, not deferred.
                if (up_req && level_q == LVL_MAX) pend_up_d = 1'b0;
                if (dn_req && level_q == '0)      pend_dn_d = 1'b0;
                if (up_req && level_q != LVL_MAX) begin
                    state_d   = PULSE_UP;
                    level_d   = level_q + 1'b1;
                    inc_d     = 1'b1;
                    cnt_d     = '0;
                    pend_up_d = 1'b0;
                end else if (dn_req && level_q != '0) begin
                    state_d   = PULSE_DN;
                    level_d   = level_q - 1'b1;
                    dec_d     = 1'b1;
                    cnt_d     = '0;
                    pend_dn_d = 1'b0;
                end
            end
            PULSE_UP, PULSE_DN: begin
                if (cnt_q == PULSE_LAST) begin
                    inc_d   = 1'b0;
                    dec_d   = 1'b0;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                inc_d   = 1'b0;
                dec_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        busy_d      = (state_d != IDLE);
        at_target_d = i_auto_en && (level_d == target_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            pend_up_q   <= 1'b0;
            pend_dn_q   <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            pend_up_q   <= pend_up_d;
            pend_dn_q   <= pend_dn_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
            ready_q     <= 1'b1;
        end
    end

    assign o_target_ready  = ready_q;
    assign o_increase_duty = inc_q;
    assign o_decrease_duty = dec_q;
    assign o_duty_level    = level_q;
    assign o_busy          = busy_q;
    assign o_at_target     = at_target_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: expected pulses go into a queue, a monitor pops them.
module tb_pwm_duty_sequencer;
    import pwm_pkg::*;

    localparam int EW = 13;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       auto_en;
    logic       tgt_valid;
    logic [3:0] tgt;
    logic       tgt_ready;
    logic       inc;
    logic       dec;
    logic [3:0] level;
    logic       busy;
    logic       at_target;
    pwm_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [EW-1:0] exp_q[$];

    pwm_duty_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_btn_up       (btn_up),
        .i_btn_down     (btn_dn),
        .i_auto_en      (auto_en),
        .i_target_valid (tgt_valid),
        .i_target       (tgt),
        .o_target_ready (tgt_ready),
        .o_increase_duty(inc),
        .o_decrease_duty(dec),
        .o_duty_level   (level),
        .o_busy         (busy),
        .o_at_target    (at_target),
        .o_dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every pulse rise is one event {dir_up, level_after, gap_since_prev_rise}.
    initial begin
        logic          prev_inc;
        logic          prev_dec;
        int            last_rise;
        int            width;
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        prev_inc  = 1'b0;
        prev_dec  = 1'b0;
        last_rise = 0;
        width     = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (inc || dec) begin
                checks++;
                if (inc && dec) begin
                    errors++;
                    $display("FAIL overlap: got inc=%0b dec=%0b, expected not both at cycle %0d", inc, dec, cyc);
                end
            end
            if ((inc && !prev_inc) || (dec && !prev_dec)) begin
                act       = {inc, level, 8'(cyc - last_rise)};
                last_rise = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got up=%0b level=%0d, expected no pulse", act[12], act[11:8]);
                end else begin
                    e = exp_q.pop_front();
                    if (act[12:8] != e[12:8] || (e[7:0] != 8'd0 && act[7:0] != e[7:0])) begin
                        errors++;
                        $display("FAIL pulse_event: got up=%0b level=%0d gap=%0d, expected up=%0b level=%0d gap=%0d",
                                 act[12], act[11:8], act[7:0], e[12], e[11:8], e[7:0]);
                    end
                end
            end
            if (inc || dec) begin
                width++;
            end else if (prev_inc || prev_dec) begin
                if (!rst) begin
                    checks++;
                    if (width != 2) begin
                        errors++;
                        $display("FAIL pulse_width: got %0d, expected 2", width);
                    end
                end
                width = 0;
            end
            prev_inc = inc;
            prev_dec = dec;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input bit up, input int lvl, input int gap);
        exp_q.push_back({up, 4'(lvl), 8'(gap)});
    endtask

    task automatic write_target(input int t);
        tgt_valid = 1'b1;
        tgt       = 4'(t);
        tick(1);
        tgt_valid = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn, input int n);
        btn_up = up;
        btn_dn = dn;
        tick(n);
        btn_up = 1'b0;
        btn_dn = 1'b0;
    endtask

    task automatic wait_level(input int lvl, input int budget);
        int n;
        n = 0;
        while (int'(level) != lvl && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_level", int'(level), lvl);
    endtask

    // Idle means three quiet cycles in a row, so the one-cycle IDLE between steps is not mistaken for done.
    task automatic wait_idle(input int budget);
        int n;
        int quiet;
        n     = 0;
        quiet = 0;
        tick(2);
        while (quiet < 3 && n < budget) begin
            tick(1);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        check("wait_idle", quiet, 3);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        btn_up    = 1'b0;
        btn_dn    = 1'b0;
        auto_en   = 1'b0;
        tgt_valid = 1'b0;
        tgt       = 4'd0;
        tick(3);
        check("rst_inc", int'(inc), 0);
        check("rst_dec", int'(dec), 0);
        check("rst_level", int'(level), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_at_target", int'(at_target), 0);
        check("rst_ready", int'(tgt_ready), 1);
        check("rst_state", int'(dbg_state), int'(IDLE));
        rst = 1'b0;
        tick(1);

        // Auto ramp 0 -> 3, then retarget to 12 (clamps to 10) while the ramp is running.
        auto_en = 1'b1;
        push(1, 1, 0);
        push(1, 2, 19);
        push(1, 3, 19);
        write_target(3);
        wait_level(3, 100);
        check("t1_at_target", int'(at_target), 1);
        check("t1_busy", int'(busy), 1);
        for (int l = 4; l <= 10; l++) push(1, l, 19);
        write_target(12);
        wait_level(10, 400);
        wait_idle(100);
        check("t2_at_target", int'(at_target), 1);
        tick(40);
        check("t2_level_hold", int'(level), 10);
        check("t2_busy", int'(busy), 0);

        // Auto ramp down 10 -> 0.
        push(0, 9, 0);
        for (int l = 8; l >= 0; l--) push(0, l, 19);
        write_target(0);
        wait_level(0, 400);
        wait_idle(100);
        check("t3_at_target", int'(at_target), 1);

        // Manual debounce: 3 cycles is too short, 4 and 100 each give one step.
        auto_en = 1'b0;
        tick(2);
        check("t4_at_target_manual", int'(at_target), 0);
        press(1, 0, 3);
        tick(30);
        check("t4_short_press", int'(level), 0);
        push(1, 1, 0);
        press(1, 0, 4);
        wait_idle(100);
        check("t4_press4", int'(level), 1);
        push(1, 2, 0);
        press(1, 0, 100);
        wait_idle(100);
        check("t4_press100", int'(level), 2);

        // Simultaneous presses: up first, then down one step period later.
        push(1, 3, 0);
        push(0, 2, 19);
        press(1, 1, 4);
        wait_idle(100);
        check("t5_net_level", int'(level), 2);
        push(0, 1, 0);
        press(0, 1, 4);
        wait_idle(100);
        push(0, 0, 0);
        press(0, 1, 4);
        wait_idle(100);
        check("t5_level_zero", int'(level), 0);
        press(0, 1, 4);
        wait_idle(100);
        check("t5_suppressed_dn", int'(level), 0);
        push(1, 1, 0);
        press(1, 0, 4);
        wait_idle(100);
        tick(30);
        check("t5_no_stale_dn", int'(level), 1);

        // Reset during the first cycle of an up pulse.
        write_target(5);
        push(1, 2, 0);
        btn_up = 1'b1;
        n = 0;
        while (!inc && n < 20) begin
            tick(1);
            n++;
        end
        check("t6_pulse_seen", int'(inc), 1);
        rst    = 1'b1;
        btn_up = 1'b0;
        tick(1);
        check("t6_inc_cleared", int'(inc), 0);
        check("t6_level", int'(level), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_state", int'(dbg_state), int'(IDLE));
        rst     = 1'b0;
        auto_en = 1'b1;
        tick(3);
        check("t6_target_zero", int'(at_target), 1);
        tick(40);
        check("t6_no_ramp", int'(level), 0);

        tick(5);
        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
